sine_bank: RTL and testbench

SINE_BANK -- requirements
Module: sine_bank

---
 rtl/sine_bank.sv | 167 ++++++++++++++++
 tb/tb_sine_bank.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sine_bank.sv
// Multi-channel sine oscillator bank: one shared external multiplier is
// time-multiplexed across channels, two multiplies per sample (fold + scale).
module sine_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PERIOD   = 48000,
  parameter int unsigned OUT_W    = 24,
  parameter int unsigned SCALE    = 250199950,
  parameter int unsigned MULT_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sync,
  input  logic [16*CHANNELS-1:0]    phase_inc,
  output logic                      finish,
  output logic [31:0]               mult_a,
  output logic [31:0]               mult_b,
  input  logic [63:0]               mult_p,
  output logic [OUT_W*CHANNELS-1:0] y
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned WAIT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [15:0] PER_C  = 16'(PERIOD);
  localparam logic [15:0] HALF_C = 16'(PERIOD / 2);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MULT_LAT > 1) ? (MULT_LAT - 2) : 0);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL1, S_WAIT1, S_MUL2, S_WAIT2, S_CAPTURE, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                finish_q, finish_d;
  logic [15:0]         acc_q [CHANNELS];
  logic [OUT_W-1:0]    y_q   [CHANNELS];

  logic [15:0]         cur_acc_s, cur_inc_s, xi_s, acc_next_s;
  logic [16:0]         sum_s;
  logic                fold_neg_s;
  logic [OUT_W-1:0]    r_s, y_next_s;
  logic                unused_mult_p_s;

  assign unused_mult_p_s = ^mult_p;

  // Half-wave fold, phase advance and sample sign for the active channel
  always_comb begin
    cur_acc_s  = acc_q[ch_q];
    cur_inc_s  = phase_inc[16*int'(ch_q) +: 16];
    fold_neg_s = (cur_acc_s >= HALF_C);
    xi_s       = fold_neg_s ? (cur_acc_s - HALF_C) : cur_acc_s;
    sum_s      = {1'b0, cur_acc_s} + {1'b0, cur_inc_s};
    if (cur_inc_s >= PER_C) begin
      acc_next_s = cur_acc_s;
    end else if (sum_s >= {1'b0, PER_C}) begin
      acc_next_s = 16'(sum_s - {1'b0, PER_C});
    end else begin
      acc_next_s = sum_s[15:0];
    end
    r_s      = mult_p[32 +: OUT_W];
    y_next_s = neg_q ? (-r_s) : r_s;
  end

  // Next-state logic and multiplier operand steering
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    finish_d = 1'b0;
    mult_a   = 32'd0;
    mult_b   = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MUL1;
          ch_d    = {CH_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL1: begin
        mult_a = {16'd0, xi_s};
        mult_b = {16'd0, HALF_C - xi_s};
        neg_d  = fold_neg_s;
        cnt_d  = WAIT_INIT;
        state_d = (MULT_LAT > 1) ? S_WAIT1 : S_MUL2;
      end
      S_WAIT1: begin
        if (cnt_q == {WAIT_W{1'b0}}) begin
          state_d = S_MUL2;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      S_MUL2: begin
        mult_a  = mult_p[31:0];
        mult_b  = 32'(SCALE);
        cnt_d   = WAIT_INIT;
        state_d = (MULT_LAT > 1) ? S_WAIT2 : S_CAPTURE;
      end
      S_WAIT2: begin
        if (cnt_q == {WAIT_W{1'b0}}) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (ch_q == CH_LAST) begin
          state_d  = S_FINISH;
          finish_d = 1'b1;
        end else begin
          state_d = S_MUL1;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, channel bookkeeping, phase accumulators and sample registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= {CH_W{1'b0}};
      cnt_q    <= {WAIT_W{1'b0}};
      neg_q    <= 1'b0;
      finish_q <= 1'b0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        acc_q[k] <= 16'd0;
        y_q[k]   <= {OUT_W{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      finish_q <= finish_d;
      // sync clears before MUL1 reads, so sync+start computes from phase 0
      if (state_q == S_IDLE && sync) begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
          acc_q[k] <= 16'd0;
        end
      end
      if (state_q == S_CAPTURE) begin
        y_q[ch_q]   <= y_next_s;
        acc_q[ch_q] <= acc_next_s;
      end
    end
  end

  assign finish = finish_q;

  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_y
    assign y[OUT_W*k +: OUT_W] = y_q[k];
  end

endmodule

// File: tb/tb_sine_bank.sv
// Directed bench for sine_bank (2 channels, 2-cycle multiplier) with an
// external registered multiplier model and hand-computed expected samples.
module tb_sine_bank;

  localparam int unsigned SCALE = 250199950;

  logic        clk = 1'b0;
  logic        rst, start, sync;
  logic [31:0] phase_inc;
  logic        finish;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_p, p1_q;
  logic [47:0] y;

  int vectors = 0;
  int miscompares = 0;

  sine_bank #(
    .CHANNELS(2), .PERIOD(48000), .OUT_W(24), .SCALE(SCALE), .MULT_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sync(sync), .phase_inc(phase_inc),
    .finish(finish), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p), .y(y)
  );

  always #5 clk = ~clk;

  // two-stage registered multiplier
  always @(posedge clk) begin
    p1_q   <= {32'd0, mult_a} * {32'd0, mult_b};
    mult_p <= p1_q;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] xi0, input logic [31:0] xi1,
                           input logic with_sync, input logic [23:0] ey0, input logic [23:0] ey1);
    logic [31:0] ea, eb;
    start = 1'b1;
    sync  = with_sync;
    @(posedge clk); #1;
    start = 1'b0;
    sync  = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      ea = 32'd0;
      eb = 32'd0;
      if (c == 1) begin ea = xi0; eb = 32'd24000 - xi0; end
      if (c == 3) begin ea = xi0 * (32'd24000 - xi0); eb = SCALE; end
      if (c == 6) begin ea = xi1; eb = 32'd24000 - xi1; end
      if (c == 8) begin ea = xi1 * (32'd24000 - xi1); eb = SCALE; end
      chk($sformatf("%s c%0d finish", tag, c), {63'd0, finish}, {63'd0, (c == 11)});
      chk($sformatf("%s c%0d mult_a", tag, c), {32'd0, mult_a}, {32'd0, ea});
      chk($sformatf("%s c%0d mult_b", tag, c), {32'd0, mult_b}, {32'd0, eb});
      if (c < 12) begin
        @(posedge clk); #1;
      end
    end
    chk({tag, " y0"}, {40'd0, y[23:0]}, {40'd0, ey0});
    chk({tag, " y1"}, {40'd0, y[47:24]}, {40'd0, ey1});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sync = 1'b0; phase_inc = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset finish", {63'd0, finish}, 64'd0);
    chk("reset mult_a", {32'd0, mult_a}, 64'd0);
    chk("reset mult_b", {32'd0, mult_b}, 64'd0);
    chk("reset y", {16'd0, y}, 64'd0);

    // basic frame timing from reset
    run_frame("t0", 32'd0, 32'd0, 1'b0, 24'h000000, 24'h000000);

    // quarter-period steps on channel 0 with wrap at PERIOD
    phase_inc = {16'd0, 16'd12000};
    run_frame("w1", 32'd0,     32'd0, 1'b0, 24'h000000, 24'h000000);
    run_frame("w2", 32'd12000, 32'd0, 1'b0, 24'h7FFFFF, 24'h000000);
    run_frame("w3", 32'd0,     32'd0, 1'b0, 24'h000000, 24'h000000);
    run_frame("w4", 32'd12000, 32'd0, 1'b0, 24'h800001, 24'h000000);
    run_frame("w5", 32'd0,     32'd0, 1'b0, 24'h000000, 24'h000000);

    // sync pulse in IDLE, then sync together with start
    run_frame("s1", 32'd12000, 32'd0, 1'b0, 24'h7FFFFF, 24'h000000);
    run_frame("s2", 32'd0,     32'd0, 1'b0, 24'h000000, 24'h000000);
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    run_frame("s3", 32'd0, 32'd0, 1'b0, 24'h000000, 24'h000000);
    run_frame("s4", 32'd0, 32'd0, 1'b1, 24'h000000, 24'h000000);

    // start held high for 30 cycles: one finish every 12 cycles
    phase_inc = {16'd6000, 16'd12000};
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 30) start = 1'b0;
      chk($sformatf("busy c%0d finish", c), {63'd0, finish},
          {63'd0, (c == 11 || c == 23 || c == 35)});
    end
    chk("busy y0", {40'd0, y[23:0]}, {40'd0, 24'h800001});
    chk("busy y1", {40'd0, y[47:24]}, {40'd0, 24'h7FFFFF});

    // reset in the middle of a frame
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("abort c%0d finish", c), {63'd0, finish}, 64'd0);
      if (c == 7) rst = 1'b1;
      if (c == 8) rst = 1'b0;
      @(posedge clk); #1;
    end
    chk("abort y", {16'd0, y}, 64'd0);

    // inc >= PERIOD holds channel 0; channel 1 steps 3/4 period
    phase_inc = {16'd36000, 16'd50000};
    run_frame("h1", 32'd0, 32'd0,     1'b0, 24'h000000, 24'h000000);
    run_frame("h2", 32'd0, 32'd12000, 1'b0, 24'h000000, 24'h800001);
    run_frame("h3", 32'd0, 32'd0,     1'b0, 24'h000000, 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
